// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - bundle input stream and instruction memory write bus
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [14:0]       ctrl;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [14:0]       imm;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_last, ctrl, rd, rs, rt, imm,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_last, ctrl, rd, rs, rt, imm,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - control bundle to opcode encoder and instruction memory loader
// Optional running XOR checksum of written words: ENCODER_CHECKSUM_EN
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int REG_AW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [ADDR_W:0]       word_count
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERROR} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic              legal;
  logic [4:0]        opcode;
  logic              use_rd, use_rs, use_rt, use_imm;
  logic [REG_AW-1:0] rd_f, rs_f, rt_f;
  logic [14:0]       imm_f;
  logic [31:0]       word;
  logic              accept, reject;

  // Exact-match reverse decode: any stray control bit makes the bundle illegal.
  always_comb begin
    legal  = 1'b1;
    opcode = 5'h00;
    case (bus.ctrl)
      15'h0000: opcode = 5'h00;
      15'h0081: opcode = 5'h01;
      15'h0091: opcode = 5'h02;
      15'h00B1: opcode = 5'h03;
      15'h00A1: opcode = 5'h04;
      15'h0041: opcode = 5'h05;
      15'h0003: opcode = 5'h06;
      15'h0005: opcode = 5'h07;
      15'h0100: opcode = 5'h08;
      15'h4001: opcode = 5'h09;
      15'h0089: opcode = 5'h0A;
      15'h0099: opcode = 5'h0B;
      15'h0090: opcode = 5'h0C;
      15'h0200: opcode = 5'h0D;
      15'h0400: opcode = 5'h0E;
      15'h1000: opcode = 5'h0F;
      15'h0800: opcode = 5'h10;
      15'h2000: opcode = 5'h11;
      default:  legal  = 1'b0;
    endcase
  end

  always_comb begin
    use_rd  = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    use_imm = 1'b0;
    case (opcode)
      5'h01, 5'h02, 5'h03, 5'h04, 5'h05: begin use_rd = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      5'h06:                             begin use_rd = 1'b1; use_rs = 1'b1; end
      5'h07, 5'h0A, 5'h0B:               begin use_rd = 1'b1; use_rs = 1'b1; use_imm = 1'b1; end
      5'h08:                             begin use_rs = 1'b1; use_rt = 1'b1; use_imm = 1'b1; end
      5'h09:                             begin use_rd = 1'b1; use_imm = 1'b1; end
      5'h0C:                             begin use_rs = 1'b1; use_rt = 1'b1; end
      5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h11: use_imm = 1'b1;
      default: ;
    endcase
    rd_f  = use_rd  ? bus.rd  : '0;
    rs_f  = use_rs  ? bus.rs  : '0;
    rt_f  = use_rt  ? bus.rt  : '0;
    imm_f = use_imm ? bus.imm : '0;
    word  = {opcode, rd_f, rs_f, rt_f, imm_f};
  end

  assign bus.in_ready = (state == S_RUN) & ~rst;
  assign busy         = (state != S_IDLE);

  // start wins over a same-cycle handshake, so that bundle is dropped.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    if (start) begin
      state_n = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (bus.in_valid) begin
            if (legal) begin
              accept = 1'b1;
              if (bus.in_last) state_n = S_DONE;
            end else begin
              reject  = 1'b1;
              state_n = S_ERROR;
            end
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_addr     <= '0;
      word_count   <= '0;
    end else begin
      state     <= state_n;
      bus.im_we <= accept;
      done      <= (state == S_DONE);
      if (accept) begin
        bus.im_addr  <= addr;
        bus.im_wdata <= word;
        addr         <= addr + 1'b1;
        if (!word_count[ADDR_W]) word_count <= word_count + 1'b1;
      end
      if (reject) begin
        err      <= 1'b1;
        err_addr <= addr;
      end
      if (start) begin
        addr       <= base_addr;
        word_count <= '0;
        err        <= 1'b0;
      end
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || start) begin
      checksum <= '0;
    end else if (bus.im_we && state != S_ERROR) begin
      checksum <= checksum ^ bus.im_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed plus randomized bench for instr_encoder_loader
module tb_instr_encoder_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy, done, err;
  logic [ADDR_W-1:0] err_addr;
  logic [ADDR_W:0]   word_count;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  instr_encoder_loader_if #(.ADDR_W(ADDR_W), .REG_AW(4)) bus ();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .REG_AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr),
    .word_count (word_count)
`ifdef ENCODER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Control bundle for each opcode, written straight from the opcode table.
  logic [14:0] legal_ctrl [18] = '{
    15'h0000, 15'h0081, 15'h0091, 15'h00B1, 15'h00A1, 15'h0041,
    15'h0003, 15'h0005, 15'h0100, 15'h4001, 15'h0089, 15'h0099,
    15'h0090, 15'h0200, 15'h0400, 15'h1000, 15'h0800, 15'h2000
  };

  logic [ADDR_W-1:0] obs_a [$];
  logic [31:0]       obs_d [$];
  logic [ADDR_W-1:0] exp_a [$];
  logic [31:0]       exp_d [$];
  int                done_cnt = 0;
  logic [ADDR_W-1:0] m_addr;

  always @(negedge clk) begin
    if (bus.im_we) begin
      obs_a.push_back(bus.im_addr);
      obs_d.push_back(bus.im_wdata);
    end
    if (done) done_cnt++;
  end

  function automatic logic [31:0] ref_word(input int op, input logic [3:0] d, input logic [3:0] s,
                                           input logic [3:0] t, input logic [14:0] im);
    bit ralu  = (op >= 1 && op <= 5);
    bit jmp   = (op >= 13 && op <= 17);
    bit immop = (op == 10 || op == 11);
    bit ud    = ralu || op == 6 || op == 7 || op == 9 || immop;
    bit us    = ralu || op == 6 || op == 7 || op == 8 || op == 12 || immop;
    bit ut    = ralu || op == 8 || op == 12;
    bit ui    = jmp || op == 7 || op == 8 || op == 9 || immop;
    logic [31:0] w;
    w = 32'(op) << 27;
    if (ud) w = w | (32'(d) << 23);
    if (us) w = w | (32'(s) << 19);
    if (ut) w = w | (32'(t) << 15);
    if (ui) w = w | 32'(im);
    return w;
  endfunction

  function automatic bit is_legal(input logic [14:0] c);
    for (int k = 0; k < 18; k++) if (legal_ctrl[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    start = 1'b1; base_addr = b;
    tick();
    start = 1'b0;
    m_addr = b;
  endtask

  task automatic drive(input logic [14:0] c, input logic [3:0] d, input logic [3:0] s,
                       input logic [3:0] t, input logic [14:0] im, input logic last);
    bus.in_valid = 1'b1; bus.ctrl = c; bus.rd = d; bus.rs = s; bus.rt = t;
    bus.imm = im; bus.in_last = last;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  // Present one legal bundle with random fields and log the word it must produce.
  task automatic put_op(input int op, input logic last);
    logic [3:0]  d, s, t;
    logic [14:0] im;
    d = 4'($urandom); s = 4'($urandom); t = 4'($urandom); im = 15'($urandom);
    drive(legal_ctrl[op], d, s, t, im, last);
    exp_a.push_back(m_addr);
    exp_d.push_back(ref_word(op, d, s, t, im));
    m_addr = m_addr + 1'b1;
    tick();
  endtask

  task automatic compare_writes(input string tag);
    check($sformatf("%s_count", tag), 64'(obs_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < obs_a.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(obs_a[i]), 64'(exp_a[i]));
        check($sformatf("%s_data%0d", tag, i), 64'(obs_d[i]), 64'(exp_d[i]));
      end
    end
  endtask

  initial begin
    logic [14:0] bad_ctrl;
    rst = 1'b1; start = 1'b0; base_addr = '0; m_addr = '0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.ctrl = '0;
    bus.rd = '0; bus.rs = '0; bus.rt = '0; bus.imm = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_im_we", bus.im_we, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_word_count", word_count, 0);
    check("rst_im_wdata", bus.im_wdata, 0);
`ifdef ENCODER_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Single ADD with in_last: write one cycle after acceptance, done one cycle later.
    clear_q();
    do_start(8'h10);
    drive(legal_ctrl[1], 4'd1, 4'd2, 4'd3, 15'($urandom), 1'b1);
    tick();
    idle();
    @(negedge clk);
    check("add_im_we", bus.im_we, 1);
    check("add_im_addr", bus.im_addr, 8'h10);
    check("add_im_wdata", bus.im_wdata, ref_word(1, 4'd1, 4'd2, 4'd3, 15'd0));
    check("add_done_early", done, 0);
    @(negedge clk);
    check("add_done", done, 1);
    check("add_word_count", word_count, 1);
    check("add_im_we_off", bus.im_we, 0);
    @(negedge clk);
    check("add_done_once", done, 0);
    check("add_busy", busy, 0);
    tick();

    // All 18 legal bundles back to back from address 0.
    clear_q();
    do_start(8'h00);
    for (int op = 0; op < 18; op++) put_op(op, op == 17);
    idle();
    repeat (4) tick();
    compare_writes("stream");
    check("stream_done_cnt", done_cnt, 1);
    check("stream_word_count", word_count, 18);

    // XOR with flags_write set is illegal: error stops the stream until start.
    clear_q();
    do_start(8'h20);
    put_op(int'($urandom_range(17)), 1'b0);
    put_op(int'($urandom_range(17)), 1'b0);
    drive(15'h00C1, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom), 1'b0);
    tick();
    drive(legal_ctrl[1], 4'd1, 4'd1, 4'd1, 15'd0, 1'b0);
    repeat (3) tick();
    idle();
    @(negedge clk);
    check("err_flag", err, 1);
    check("err_addr", err_addr, 8'h22);
    check("err_in_ready", bus.in_ready, 0);
    check("err_busy", busy, 1);
    compare_writes("err");
    tick();

    // Random illegal bundle carrying in_last: error, no write, no done.
    clear_q();
    do_start(8'h28);
    @(negedge clk);
    check("restart_err_clear", err, 0);
    check("restart_in_ready", bus.in_ready, 1);
    bad_ctrl = 15'($urandom);
    for (int k = 0; k < 64 && is_legal(bad_ctrl); k++) bad_ctrl = 15'($urandom);
    drive(bad_ctrl, 4'd0, 4'd0, 4'd0, 15'd0, 1'b1);
    tick();
    idle();
    repeat (3) tick();
    check("ill_last_err", err, 1);
    check("ill_last_err_addr", err_addr, 8'h28);
    check("ill_last_done_cnt", done_cnt, 0);
    compare_writes("ill_last");

    // Address wrap from 0xFE.
    clear_q();
    do_start(8'hFE);
    for (int k = 0; k < 3; k++) put_op(int'($urandom_range(17)), k == 2);
    idle();
    repeat (4) tick();
    compare_writes("wrap");
    if (obs_a.size() >= 3) check("wrap_to_zero", obs_a[2], 8'h00);
    check("wrap_word_count", word_count, 3);

    // Toggling in_valid, last on the 4th bundle, then in_valid while idle is ignored.
    clear_q();
    do_start(8'h40);
    for (int k = 0; k < 4; k++) begin
      put_op(int'($urandom_range(17)), k == 3);
      idle();
      tick();
    end
    drive(legal_ctrl[2], 4'd5, 4'd6, 4'd7, 15'd9, 1'b0);
    repeat (3) tick();
    idle();
    repeat (2) tick();
    compare_writes("toggle");
    check("toggle_done_cnt", done_cnt, 1);

    // Reset mid-stream: writes already in flight show, nothing after.
    clear_q();
    do_start(8'h50);
    put_op(int'($urandom_range(17)), 1'b0);
    put_op(int'($urandom_range(17)), 1'b0);
    drive(legal_ctrl[3], 4'd1, 4'd2, 4'd3, 15'd4, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_im_we", bus.im_we, 0);
    check("midrst_im_addr", bus.im_addr, 0);
    check("midrst_im_wdata", bus.im_wdata, 0);
    check("midrst_busy", busy, 0);
    check("midrst_word_count", word_count, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    idle();
    compare_writes("midrst");

    // start while running: in-flight write keeps its address, same-cycle bundle dropped.
    clear_q();
    do_start(8'h60);
    put_op(int'($urandom_range(17)), 1'b0);
    start = 1'b1; base_addr = 8'h70;
    drive(legal_ctrl[4], 4'd8, 4'd9, 4'd10, 15'd11, 1'b0);
    tick();
    start = 1'b0;
    m_addr = 8'h70;
    put_op(int'($urandom_range(17)), 1'b1);
    idle();
    repeat (4) tick();
    compare_writes("restart");
    check("restart_word_count", word_count, 1);
    check("restart_done_cnt", done_cnt, 1);

`ifdef ENCODER_CHECKSUM_EN
    clear_q();
    do_start(8'h00);
    drive(legal_ctrl[9], 4'd1, 4'($urandom), 4'($urandom), 15'h0005, 1'b0);
    tick();
    drive(legal_ctrl[17], 4'($urandom), 4'($urandom), 4'($urandom), 15'h0020, 1'b1);
    tick();
    idle();
    repeat (4) tick();
    check("checksum", checksum, 32'hC0800025);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
